// File: rtl/issueque_div_pkg.sv
// Shared execution-unit widths and the issue-queue entry record used by the
// divider issue queue and its entry slices.
package issueque_div_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;

  typedef struct packed {
    logic              valid;
    logic              rs_rdy;
    logic              rt_rdy;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [TAG_W-1:0]  rs_tag;
    logic [TAG_W-1:0]  rt_tag;
    logic [TAG_W-1:0]  rd_tag;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/issueque_div_entry.sv
// One issue-queue slot: registers the contents chosen by the queue (hold,
// shift-in or new dispatch) after letting the CDB fill any waiting operand.
module issueque_div_entry
  import issueque_div_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] src,
  input  logic               cdb_valid,
  input  logic [TAG_W-1:0]   cdb_tag,
  input  logic [DATA_W-1:0]  cdb_data,
  output logic [ENTRY_W-1:0] cur,
  output logic               ready
);

  entry_t s;
  entry_t n;
  entry_t q;

  // Snooping the incoming record covers held, shifted and freshly dispatched
  // contents alike, so a same-cycle broadcast is never lost.
  always_comb begin
    s = src;
    n = s;
    if (s.valid && !s.rs_rdy && cdb_valid && (cdb_tag == s.rs_tag)) begin
      n.rs_rdy  = 1'b1;
      n.rs_data = cdb_data;
    end
    if (s.valid && !s.rt_rdy && cdb_valid && (cdb_tag == s.rt_tag)) begin
      n.rt_rdy  = 1'b1;
      n.rt_data = cdb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (flush) begin
      q.valid  <= 1'b0;
      q.rs_rdy <= 1'b0;
      q.rt_rdy <= 1'b0;
    end else begin
      q <= n;
    end
  end

  assign cur   = q;
  assign ready = q.valid & q.rs_rdy & q.rt_rdy;

endmodule

// File: rtl/issueque_div.sv
// Age-ordered collapsing issue queue feeding a single non-pipelined divider;
// entry 0 is always the oldest and valid entries are packed from index 0.
module issueque_div
  import issueque_div_pkg::*;
#(
  parameter int DEPTH = 4
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              dispatch_div_enable,
  input  logic [DATA_W-1:0] dispatch_rsdata,
  input  logic [DATA_W-1:0] dispatch_rtdata,
  input  logic              dispatch_rsvalid,
  input  logic              dispatch_rtvalid,
  input  logic [TAG_W-1:0]  dispatch_rstag,
  input  logic [TAG_W-1:0]  dispatch_rttag,
  input  logic [TAG_W-1:0]  dispatch_rdtag,
  output logic              issueque_div_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              flush,
  input  logic              issuediv_busy,
  output logic              issuediv_enable,
  output logic [DATA_W-1:0] issuediv_rsdata,
  output logic [DATA_W-1:0] issuediv_rtdata,
  output logic [TAG_W-1:0]  issuediv_rdtag
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  entry_t           q     [DEPTH];
  entry_t           q_up  [DEPTH];
  entry_t           src   [DEPTH];
  entry_t           disp_entry;
  logic [DEPTH-1:0] rdy;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] wr_slot;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             disp_accept;
  logic             issue_fire;

  assign issueque_div_full = (count == CNT_W'(DEPTH));
  assign disp_accept       = dispatch_div_enable && !issueque_div_full && !flush;
  // Blocking selection while enable is high leaves the divider a cycle to raise busy.
  assign issue_fire        = sel_found && !issuediv_busy && !issuediv_enable && !flush;
  assign wr_slot           = issue_fire ? (count - CNT_W'(1)) : count;

  always_comb begin
    disp_entry         = '0;
    disp_entry.valid   = 1'b1;
    disp_entry.rs_rdy  = dispatch_rsvalid;
    disp_entry.rt_rdy  = dispatch_rtvalid;
    disp_entry.rs_data = dispatch_rsdata;
    disp_entry.rt_data = dispatch_rtdata;
    disp_entry.rs_tag  = dispatch_rstag;
    disp_entry.rt_tag  = dispatch_rttag;
    disp_entry.rd_tag  = dispatch_rdtag;
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      src[i] = q[i];
      if (issue_fire && (i >= int'(sel_idx)))
        src[i] = q_up[i];
      if (disp_accept && (i == int'(wr_slot)))
        src[i] = disp_entry;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    if (g < DEPTH - 1) begin : g_up
      assign q_up[g] = q[g+1];
    end else begin : g_last
      assign q_up[g] = '0;
    end

    issueque_div_entry u_entry (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .src       (src[g]),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cur       (q[g]),
      .ready     (rdy[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (flush)
      count <= '0;
    else
      count <= count - CNT_W'(issue_fire) + CNT_W'(disp_accept);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issuediv_enable <= 1'b0;
      issuediv_rsdata <= '0;
      issuediv_rtdata <= '0;
      issuediv_rdtag  <= '0;
    end else if (flush) begin
      issuediv_enable <= 1'b0;
    end else if (issue_fire) begin
      issuediv_enable <= 1'b1;
      issuediv_rsdata <= q[sel_idx].rs_data;
      issuediv_rtdata <= q[sel_idx].rt_data;
      issuediv_rdtag  <= q[sel_idx].rd_tag;
    end else begin
      issuediv_enable <= 1'b0;
    end
  end

endmodule
